spi_rdid_master: RTL and testbench
==================================

Name: spi_rdid_master

Overview:
- SPI mode-0 initiator that issues the JEDEC Read-ID command to the serial configuration flash.
- Captures the three response bytes: manufacturer ID, memory type and memory capacity.
- Holds the captured bytes stable in registers for the LED display selector.
- Sits between the board flash pins and the display path. It is triggered by a start pulse from a debounced button or a power-on sequencer.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period. Legal range 2..255.
- CMD, 8'h9F: command byte shifted out MSB first.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle request to run one RDID transaction.
- miso, input, 1: flash serial data out.
- sclk, output, 1: SPI clock. Idles low.
- cs_n, output, 1: flash chip select, active low.
- mosi, output, 1: flash serial data in.
- busy, output, 1: high while a transaction is in progress.
- done, output, 1: one-cycle pulse when new IDs are valid.
- manufacture_id, output, 8: first response byte.
- memory_type, output, 8: second response byte.
- memory_capacity, output, 8: third response byte.

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, all three ID outputs = 8'h00, FSM in IDLE, divider counter = 0, bit counter = 0.
- Reset is asynchronous. Asserting it mid-transaction forces cs_n high and sclk low in the same instant and clears all ID outputs. No partial result is kept.
- States and transitions:
  - IDLE: cs_n=1, sclk=0, busy=0. If start=1 is sampled at edge N, go to SETUP. From edge N: cs_n=0, busy=1, mosi=CMD[7].
  - SETUP: hold for CLK_DIV cycles with sclk low. This is the CS-to-first-edge setup time. Then go to SHIFT.
  - SHIFT: 32 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
    - On each sclk 0->1 transition, sample miso into a 32-bit shift register.
    - On each sclk 1->0 transition, drive the next mosi bit.
    - Bits 7..0 of CMD go out on periods 0..7. mosi=0 for periods 8..31.
    - Bit counter is 0..31. After the low half of period 31, go to HOLD.
  - HOLD: cs_n=1, sclk=0, mosi=0 for CLK_DIV cycles. This is the CS deselect time.
    - On the first HOLD cycle, latch shift[23:16] into manufacture_id, shift[15:8] into memory_type and shift[7:0] into memory_capacity.
    - done=1 for exactly that one cycle.
    - After CLK_DIV cycles return to IDLE with busy=0.
- Bits sampled during periods 0..7 (the command phase) are discarded.
- Timing with start sampled at edge N:
  - cs_n is low for exactly (1+64)*CLK_DIV cycles.
  - done pulses at edge N+65*CLK_DIV.
  - busy falls at edge N+66*CLK_DIV.
  - At CLK_DIV=4: cs_n low for 260 cycles, done at N+260, busy low at N+264.
- start while busy=1 is ignored. It is not queued.
- start held high for multiple cycles in IDLE launches exactly one transaction. A new transaction launches only if start is still high when the FSM is back in IDLE.
- ID outputs change only on the done cycle. They hold their previous values throughout a transaction.
- sclk, cs_n and mosi are driven directly from flops and are glitch-free.

Test Plan:
- Reset behaviour: assert reset, release, idle 20 cycles -> cs_n=1, sclk=0, busy=0, done=0, all IDs 8'h00, no sclk edges.
- Nominal read: CLK_DIV=4, flash model returns 8'h20, 8'h20, 8'h16 (24'h202016) on the first transaction and 8'hEF, 8'h40, 8'h18 on a second. Required response:
  - mosi shows 1001_1111 on the first 8 rising sclk edges.
  - Exactly 32 sclk rising edges per transaction.
  - manufacture_id=8'h20, memory_type=8'h20, memory_capacity=8'h16.
  - done pulses once at start+260 cycles; busy drops at start+264.
  - A second start with the other model data updates the outputs to 8'hEF, 8'h40, 8'h18 only at the second done.
- Busy and held-start handling: start pulses at cycles 10 and 50 (mid-transaction), CLK_DIV=2 -> only one transaction; cs_n low for 130 cycles; start held high continuously -> back-to-back transactions separated by at least the HOLD time with cs_n high.
- Reset mid-operation: assert reset during SHIFT bit 15 -> cs_n=1 and sclk=0 immediately, IDs stay 8'h00. After release, a fresh start returns correct IDs.
- Timing check: CLK_DIV=2 and CLK_DIV=7 -> sclk high and low phases are exactly CLK_DIV cycles; CS setup to the first rising edge is CLK_DIV cycles; miso changed by the model on falling edges is captured with no bit slip. Pattern 8'hA5, 8'h5A, 8'hC3 is read back exactly.

Source files
------------

// File: rtl/spi_rdid_master_if.sv
// spi_rdid_master_if: handshake, flash pins and ID outputs of the Read-ID master
// Signals: start/busy/done (request handshake), sclk/cs_n/mosi/miso (flash pins),
//          manufacture_id/memory_type/memory_capacity (captured ID bytes)
// Modports: master (the SPI initiator), slave (requester, flash and display side)
interface spi_rdid_master_if;
    logic       start;
    logic       miso;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       busy;
    logic       done;
    logic [7:0] manufacture_id;
    logic [7:0] memory_type;
    logic [7:0] memory_capacity;
    modport master (
        input  start, miso,
        output sclk, cs_n, mosi, busy, done, manufacture_id, memory_type, memory_capacity
    );
    modport slave (
        output start, miso,
        input  sclk, cs_n, mosi, busy, done, manufacture_id, memory_type, memory_capacity
    );
endinterface

// File: rtl/spi_rdid_master.sv
// spi_rdid_master: SPI mode-0 initiator that runs one JEDEC Read-ID and holds the 3 ID bytes
// Ports: clk (rising edge), reset (asynchronous, active high),
//        bus (master modport: start/busy/done handshake, sclk/cs_n/mosi/miso flash pins,
//             manufacture_id/memory_type/memory_capacity held ID bytes)
// Parameters: CLK_DIV (system clocks per SCLK half-period, 2..255), CMD (command byte, MSB first)
module spi_rdid_master #(
    parameter int         CLK_DIV = 4,
    parameter logic [7:0] CMD     = 8'h9F
) (
    input logic               clk,
    input logic               reset,
    spi_rdid_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [4:0]  bitc, bitc_d;
    logic [23:0] shift, shift_d;
    logic [23:0] ids, ids_d;
    logic        sclk, sclk_d, cs_n, cs_n_d, mosi, mosi_d, busy, busy_d, done, done_d;
    logic        last;

    assign last = cnt == 8'(CLK_DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            bitc  <= '0;
            shift <= '0;
            ids   <= '0;
            sclk  <= 1'b0;
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            bitc  <= bitc_d;
            shift <= shift_d;
            ids   <= ids_d;
            sclk  <= sclk_d;
            cs_n  <= cs_n_d;
            mosi  <= mosi_d;
            busy  <= busy_d;
            done  <= done_d;
        end

    // Only the last 24 samples matter; the command-phase samples fall off the top of shift.
    always_comb begin
        state_d = state;
        cnt_d   = last ? '0 : cnt + 8'd1;
        bitc_d  = bitc;
        shift_d = shift;
        ids_d   = ids;
        sclk_d  = sclk;
        cs_n_d  = cs_n;
        mosi_d  = mosi;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = CMD[7];
                    bitc_d  = '0;
                end
            end
            SETUP:
                if (last) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    shift_d = {shift[22:0], bus.miso};
                end
            SHIFT:
                if (last) begin
                    if (sclk) begin
                        sclk_d = 1'b0;
                        mosi_d = (bitc < 5'd7) ? CMD[3'd6 - bitc[2:0]] : 1'b0;
                    end else if (bitc == 5'd31) begin
                        state_d = HOLD;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                        ids_d   = shift;
                    end else begin
                        sclk_d  = 1'b1;
                        bitc_d  = bitc + 5'd1;
                        shift_d = {shift[22:0], bus.miso};
                    end
                end
            HOLD:
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sclk            = sclk;
    assign bus.cs_n            = cs_n;
    assign bus.mosi            = mosi;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.manufacture_id  = ids[23:16];
    assign bus.memory_type     = ids[15:8];
    assign bus.memory_capacity = ids[7:0];
endmodule

// File: tb/tb_spi_rdid_master.sv
// tb_spi_rdid_master: three masters (CLK_DIV 4, 2, 7) against a behavioural flash and timing model
module tb_spi_rdid_master;
    function automatic int div_of(input int k);
        return k == 0 ? 4 : k == 1 ? 2 : 7;
    endfunction

    typedef struct {
        int          k;
        logic [23:0] id;
        int          cs_low;
        int          done_off;
        int          busy_off;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        start_a [3];
    logic        miso_a  [3];
    logic        sclk_a  [3];
    logic        cs_a    [3];
    logic        mosi_a  [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [23:0] id_a    [3];
    logic [23:0] flash_id[3];

    bit          prev_cs  [3] = '{1'b1, 1'b1, 1'b1};
    bit          prev_sclk[3];
    bit          prev_busy[3];
    logic [23:0] prev_id  [3] = '{default: '0};
    logic [31:0] resp     [3];
    logic [31:0] mosi_bits[3];
    logic [23:0] done_id  [3];
    int rises[3], total_rises[3], setup[3], phase_bad[3], last_edge[3];
    int cs_fall_cyc[3], cs_rise_cyc[3], cs_low[3], gap[3], txn_cnt[3];
    int done_cnt[3], done_cyc[3], busy_fall_cyc[3], glitch[3], stray[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        spi_rdid_master_if bus ();
        spi_rdid_master #(.CLK_DIV(div_of(g)), .CMD(8'h9F)) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
        assign bus.start = start_a[g];
        assign bus.miso  = miso_a[g];
        assign sclk_a[g] = bus.sclk;
        assign cs_a[g]   = bus.cs_n;
        assign mosi_a[g] = bus.mosi;
        assign busy_a[g] = bus.busy;
        assign done_a[g] = bus.done;
        assign id_a[g]   = {bus.manufacture_id, bus.memory_type, bus.memory_capacity};
    end

    // Flash model: a dummy byte during the command then the 24-bit ID, MSB first, shifted on
    // sclk falling edges. Also measures every timing relation seen on the pins.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (prev_cs[k] && !cs_a[k]) begin
                resp[k]        = {8'($urandom), flash_id[k]};
                miso_a[k]      = resp[k][31];
                gap[k]         = cyc - cs_rise_cyc[k];
                cs_fall_cyc[k] = cyc;
                rises[k]       = 0;
                mosi_bits[k]   = '0;
                phase_bad[k]   = 0;
            end
            if (!prev_cs[k] && cs_a[k]) begin
                cs_low[k]      = cyc - cs_fall_cyc[k];
                cs_rise_cyc[k] = cyc;
                txn_cnt[k]++;
                if (cyc - last_edge[k] != div_of(k)) phase_bad[k]++;
            end
            if (!prev_sclk[k] && sclk_a[k]) begin
                if (cs_a[k]) stray[k]++;
                if (rises[k] == 0) setup[k] = cyc - cs_fall_cyc[k];
                else if (cyc - last_edge[k] != div_of(k)) phase_bad[k]++;
                rises[k]++;
                total_rises[k]++;
                mosi_bits[k] = {mosi_bits[k][30:0], mosi_a[k]};
                last_edge[k] = cyc;
            end
            if (prev_sclk[k] && !sclk_a[k]) begin
                if (cyc - last_edge[k] != div_of(k)) phase_bad[k]++;
                resp[k]      = resp[k] << 1;
                miso_a[k]    = resp[k][31];
                last_edge[k] = cyc;
            end
            if (done_a[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
                done_id[k]  = id_a[k];
            end
            if (prev_busy[k] && !busy_a[k]) busy_fall_cyc[k] = cyc;
            if (!reset && id_a[k] !== prev_id[k] && !done_a[k]) glitch[k]++;
            prev_cs[k]   = cs_a[k];
            prev_sclk[k] = sclk_a[k];
            prev_busy[k] = busy_a[k];
            prev_id[k]   = id_a[k];
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d]: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    task automatic wait_idle(input int k, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy_a[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, k, 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v);
        int n, d0, t0, d;
        d              = div_of(v.k);
        flash_id[v.k]  = v.id;
        d0             = done_cnt[v.k];
        t0             = txn_cnt[v.k];
        @(negedge clk);
        start_a[v.k] = 1'b1;
        n            = cyc + 1;
        @(negedge clk);
        start_a[v.k] = 1'b0;
        wait_idle(v.k, "txn_timeout");
        chk("done_count", v.k, 32'(done_cnt[v.k] - d0), 32'd1);
        chk("txn_count", v.k, 32'(txn_cnt[v.k] - t0), 32'd1);
        chk("done_time", v.k, 32'(done_cyc[v.k] - n), 32'(v.done_off));
        chk("busy_fall_time", v.k, 32'(busy_fall_cyc[v.k] - n), 32'(v.busy_off));
        chk("cs_low_len", v.k, 32'(cs_low[v.k]), 32'(v.cs_low));
        chk("sclk_rises", v.k, 32'(rises[v.k]), 32'd32);
        chk("mosi_bits", v.k, mosi_bits[v.k], 32'h9F00_0000);
        chk("phase_len_errs", v.k, 32'(phase_bad[v.k]), 32'd0);
        chk("cs_setup", v.k, 32'(setup[v.k]), 32'(d));
        chk("ids_at_done", v.k, 32'(done_id[v.k]), 32'(v.id));
        chk("ids_held", v.k, 32'(id_a[v.k]), 32'(v.id));
    endtask

    initial begin
        vec_t vt[4];
        vec_t v;
        int   t0, d0, r0[3];
        bit   ok;
        vt[0] = '{0, 24'h202016, 260, 260, 264};
        vt[1] = '{0, 24'hEF4018, 260, 260, 264};
        vt[2] = '{1, 24'hA55AC3, 130, 130, 132};
        vt[3] = '{2, 24'hA55AC3, 455, 455, 462};
        for (int k = 0; k < 3; k++) begin
            start_a[k]  = 1'b0;
            miso_a[k]   = 1'b0;
            flash_id[k] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) r0[k] = total_rises[k];
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_cs_n", k, 32'(cs_a[k]), 32'd1);
            chk("rst_sclk", k, 32'(sclk_a[k]), 32'd0);
            chk("rst_mosi", k, 32'(mosi_a[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_a[k]), 32'd0);
            chk("rst_done_seen", k, 32'(done_cnt[k]), 32'd0);
            chk("rst_ids", k, 32'(id_a[k]), 32'd0);
            chk("rst_sclk_edges", k, 32'(total_rises[k] - r0[k]), 32'd0);
        end

        for (int i = 0; i < 4; i++) run_txn(vt[i]);

        // start pulses mid-transaction are dropped, not queued
        t0 = txn_cnt[1];
        repeat (10) @(negedge clk);
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        repeat (39) @(negedge clk);
        chk("busy_mid", 1, 32'(busy_a[1]), 32'd1);
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        wait_idle(1, "pulse_timeout");
        repeat (20) @(negedge clk);
        chk("pulse_txns", 1, 32'(txn_cnt[1] - t0), 32'd1);
        chk("pulse_cs_low", 1, 32'(cs_low[1]), 32'd130);
        chk("pulse_idle_after", 1, 32'(busy_a[1]), 32'd0);

        // start held high: back-to-back transactions with the deselect gap
        flash_id[1] = 24'h3C96E1;
        t0 = txn_cnt[1];
        d0 = done_cnt[1];
        ok = 1'b0;
        start_a[1] = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (txn_cnt[1] - t0 >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        start_a[1] = 1'b0;
        chk("held_timeout", 1, 32'(ok), 32'd1);
        wait_idle(1, "held_idle_timeout");
        repeat (10) @(negedge clk);
        chk("held_txns", 1, 32'(txn_cnt[1] - t0), 32'd3);
        chk("held_dones", 1, 32'(done_cnt[1] - d0), 32'd3);
        chk("held_gap", 1, 32'(gap[1]), 32'(div_of(1) + 1));
        chk("held_cs_low", 1, 32'(cs_low[1]), 32'd130);
        chk("held_ids", 1, 32'(id_a[1]), 32'h3C96E1);

        // reset while sclk is high in period 15
        flash_id[0] = 24'h5A5A5A;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rises[0] == 16 && sclk_a[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reach", 0, 32'(ok), 32'd1);
        chk("mid_cs_before", 0, 32'(cs_a[0]), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs_n", 0, 32'(cs_a[0]), 32'd1);
        chk("mid_rst_sclk", 0, 32'(sclk_a[0]), 32'd0);
        chk("mid_rst_busy", 0, 32'(busy_a[0]), 32'd0);
        chk("mid_rst_ids", 0, 32'(id_a[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_ids_after", 0, 32'(id_a[0]), 32'd0);
        v = '{0, 24'hC0FFEE, 260, 260, 264};
        run_txn(v);

        for (int i = 0; i < 6; i++) begin
            v.k        = int'($urandom_range(0, 2));
            v.id       = 24'($urandom);
            v.cs_low   = 65 * div_of(v.k);
            v.done_off = 65 * div_of(v.k);
            v.busy_off = 66 * div_of(v.k);
            run_txn(v);
        end

        for (int k = 0; k < 3; k++) begin
            chk("id_change_without_done", k, 32'(glitch[k]), 32'd0);
            chk("sclk_edge_with_cs_high", k, 32'(stray[k]), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
